keypad_event_scanner: RTL and testbench

- Upstream input stage for the tic-tac-toe game logic.
- Drives the 3-column keypad scan and samples the 4 row lines.
- Debounces over whole scans and emits exactly one single-cycle `key_valid` event per clean key press, with a 4-bit key code.
- The game/board logic consumes this event instead of a level-sensitive key value.

---
 rtl/ttt_pkg.sv | 35 +++
 rtl/keypad_snapshot_decode.sv | 22 ++
 rtl/keypad_event_scanner.sv | 115 +++++++++++
 tb/tb_keypad_event_scanner.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared keypad types and constants for the tic-tac-toe input path.
`timescale 1ns/1ps
package ttt_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [2:0] COL1 = 3'b001;
    localparam logic [2:0] COL2 = 3'b010;
    localparam logic [2:0] COL3 = 3'b100;

    localparam int SNAP_W = 12;

    typedef enum logic {
        ARMED,
        PRESSED
    } state_t;

    function automatic int snap_idx(input int row, input int col);
        return row * 3 + col;
    endfunction

    // Bits 0..8 are digits 1..9; the bottom row is *, 0, #.
    function automatic logic [3:0] idx_code(input int idx);
        if (idx < 9)
            return 4'(idx + 1);
        else if (idx == 9)
            return KEY_STAR;
        else if (idx == 10)
            return 4'd0;
        else
            return KEY_HASH;
    endfunction

endpackage

// File: rtl/keypad_snapshot_decode.sv
// Classifies a 12-bit scan snapshot and decodes a single pressed key.
`timescale 1ns/1ps
module keypad_snapshot_decode
    import ttt_pkg::*;
(
    input  logic [SNAP_W-1:0] snap,
    output logic              is_onehot,
    output logic              is_zero,
    output logic [3:0]        code
);

    always_comb begin
        is_zero   = (snap == '0);
        is_onehot = $onehot(snap);
        code      = 4'd0;
        for (int i = 0; i < SNAP_W; i++) begin
            if (snap[i])
                code = idx_code(i);
        end
    end

endmodule

// File: rtl/keypad_event_scanner.sv
// 3x4 keypad scanner with whole-scan debounce and one-shot key events.
`timescale 1ns/1ps
module keypad_event_scanner
    import ttt_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0]     cnt;
    logic [1:0]        colidx;
    logic [SNAP_W-1:0] cur;
    logic [SNAP_W-1:0] prev;
    logic [SNAP_W-1:0] snap_now;
    logic [SW-1:0]     stable_cnt;
    logic [SW-1:0]     cnt_nxt;
    state_t            state;

    logic       slot_end;
    logic       scan_end;
    logic       stable;
    logic       is_onehot;
    logic       is_zero;
    logic [3:0] code;

    assign slot_end = (cnt == CW'(SCAN_DIV - 1));
    assign scan_end = slot_end && (colidx == 2'd2);

    // Current column's rows merged in, so the compare sees a full scan.
    always_comb begin
        snap_now = cur;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (colidx == 2'(c))
                    snap_now[snap_idx(r, c)] = key_row[r];
            end
        end
    end

    always_comb begin
        cnt_nxt = SW'(1);
        if (snap_now == prev) begin
            if (stable_cnt == SW'(DEBOUNCE_SCANS))
                cnt_nxt = stable_cnt;
            else
                cnt_nxt = stable_cnt + SW'(1);
        end
    end

    assign stable = (cnt_nxt == SW'(DEBOUNCE_SCANS));

    keypad_snapshot_decode u_decode (
        .snap      (snap_now),
        .is_onehot (is_onehot),
        .is_zero   (is_zero),
        .code      (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            colidx     <= 2'd0;
            key_col    <= COL1;
            cur        <= '0;
            prev       <= '0;
            stable_cnt <= '0;
            state      <= ARMED;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
            key_held   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (slot_end) begin
                cnt     <= '0;
                cur     <= snap_now;
                colidx  <= (colidx == 2'd2) ? 2'd0 : colidx + 2'd1;
                key_col <= {key_col[1:0], key_col[2]};
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (scan_end) begin
                stable_cnt <= cnt_nxt;
                prev       <= snap_now;
                unique case (state)
                    ARMED: begin
                        if (stable && is_onehot) begin
                            state     <= PRESSED;
                            key_valid <= 1'b1;
                            key_code  <= code;
                            key_held  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (stable && is_zero) begin
                            state    <= ARMED;
                            key_held <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed bench for keypad_event_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
`timescale 1ns/1ps
module tb_keypad_event_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [11:0] keys = '0;
    int          checks = 0;
    int          passed = 0;
    int          pulses = 0;
    logic [3:0]  last_code = '0;
    logic        last_held = 1'b0;

    keypad_event_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its row to the driven column.
    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && key_col[c])
                    key_row[r] = 1'b1;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses    <= pulses + 1;
            last_code <= key_code;
            last_held <= key_held;
        end
    end

    task automatic wait_pulse(input int budget, output int n);
        int base;
        base = pulses;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            #1;
            if (pulses != base) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (key_held == 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({key_col, key_valid, key_code, key_held} !== {3'b001, 1'b0, 4'd0, 1'b0})
            $display("FAIL reset_async: got col=%b v=%b code=%0d held=%b want 001/0/0/0",
                     key_col, key_valid, key_code, key_held);
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (key_col !== 3'b001)
            $display("FAIL col_after_release: got %b want 001", key_col);
        else
            passed++;
        repeat (4) @(negedge clk);
        checks++;
        if (key_col !== 3'b010)
            $display("FAIL col_step1: got %b want 010", key_col);
        else
            passed++;
        repeat (4) @(negedge clk);
        checks++;
        if (key_col !== 3'b100)
            $display("FAIL col_step2: got %b want 100", key_col);
        else
            passed++;
        repeat (4) @(negedge clk);
        checks++;
        if (key_col !== 3'b001)
            $display("FAIL col_step3: got %b want 001", key_col);
        else
            passed++;
    endtask

    task automatic test_single_press();
        int n;
        int base;
        keys = 12'b1 << 4;
        wait_pulse(50, n);
        checks++;
        if (n < 0)
            $display("FAIL press5_latency: no pulse within 50 cycles, want <= 50");
        else
            passed++;
        checks++;
        if (last_code !== 4'd5)
            $display("FAIL press5_code: got %0d want 5", last_code);
        else
            passed++;
        checks++;
        if (last_held !== 1'b1)
            $display("FAIL press5_held: got %b want 1", last_held);
        else
            passed++;
        base = pulses;
        repeat (200) @(negedge clk);
        checks++;
        if (pulses != base)
            $display("FAIL press5_no_repeat: got %0d extra pulses want 0", pulses - base);
        else
            passed++;
        checks++;
        if (key_held !== 1'b1)
            $display("FAIL press5_still_held: got %b want 1", key_held);
        else
            passed++;
    endtask

    task automatic test_release_repress();
        int n;
        int base;
        base = pulses;
        keys = '0;
        wait_release(60, n);
        checks++;
        if (n < 0)
            $display("FAIL release5: key_held stuck at 1 after 60 cycles, want 0");
        else
            passed++;
        checks++;
        if (pulses != base)
            $display("FAIL release5_no_pulse: got %0d pulses want 0", pulses - base);
        else
            passed++;
        keys = 12'b1 << 11;
        wait_pulse(50, n);
        checks++;
        if (n < 0 || last_code !== 4'd11)
            $display("FAIL press_hash: n=%0d code=%0d want pulse with code 11", n, last_code);
        else
            passed++;
        keys = '0;
        wait_release(60, n);
        checks++;
        if (n < 0)
            $display("FAIL release_hash: key_held stuck at 1, want 0");
        else
            passed++;
    endtask

    task automatic test_bounce();
        int n;
        int base;
        base = pulses;
        // Flip once per scan so no two consecutive snapshots agree.
        for (int i = 0; i < 9; i++) begin
            keys[0] = ~keys[0];
            repeat (12) @(negedge clk);
        end
        checks++;
        if (pulses != base)
            $display("FAIL bounce_quiet: got %0d pulses want 0", pulses - base);
        else
            passed++;
        keys = 12'b1;
        wait_pulse(50, n);
        checks++;
        if (n < 0 || last_code !== 4'd1)
            $display("FAIL bounce_settle: n=%0d code=%0d want pulse with code 1", n, last_code);
        else
            passed++;
        base = pulses;
        keys = '0;
        wait_release(60, n);
        checks++;
        if (n < 0 || pulses != base)
            $display("FAIL bounce_release: n=%0d extra=%0d want release, 0 pulses",
                     n, pulses - base);
        else
            passed++;
    endtask

    task automatic test_two_keys();
        int n;
        int base;
        base = pulses;
        keys = (12'b1 << 0) | (12'b1 << 8);
        repeat (72) @(negedge clk);
        checks++;
        if (pulses != base || key_held !== 1'b0)
            $display("FAIL two_keys_quiet: pulses=%0d held=%b want 0/0",
                     pulses - base, key_held);
        else
            passed++;
        keys = 12'b1;
        wait_pulse(50, n);
        checks++;
        if (n < 0 || last_code !== 4'd1)
            $display("FAIL two_keys_drop9: n=%0d code=%0d want pulse with code 1", n, last_code);
        else
            passed++;
        keys = '0;
        wait_release(60, n);
        checks++;
        if (n < 0)
            $display("FAIL two_keys_release: key_held stuck at 1, want 0");
        else
            passed++;
        keys = 12'b1 << 10;
        wait_pulse(50, n);
        checks++;
        if (n < 0 || last_code !== 4'd0)
            $display("FAIL press_zero: n=%0d code=%0d want pulse with code 0", n, last_code);
        else
            passed++;
        keys = '0;
        wait_release(60, n);
        checks++;
        if (n < 0)
            $display("FAIL zero_release: key_held stuck at 1, want 0");
        else
            passed++;
    endtask

    task automatic test_reset_mid_debounce();
        int k;
        int base;
        int first;
        k = 0;
        while (key_col !== 3'b100 && k < 40) begin
            @(negedge clk);
            k++;
        end
        while (key_col !== 3'b001 && k < 80) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (key_col !== 3'b001)
            $display("FAIL scan_sync: got col %b want 001", key_col);
        else
            passed++;
        base = pulses;
        keys = 12'b1 << 6;
        repeat (24) @(negedge clk);
        checks++;
        if (pulses != base)
            $display("FAIL pre_reset_quiet: got %0d pulses want 0", pulses - base);
        else
            passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({key_col, key_valid, key_held} !== {3'b001, 1'b0, 1'b0})
            $display("FAIL mid_reset_outputs: col=%b v=%b held=%b want 001/0/0",
                     key_col, key_valid, key_held);
        else
            passed++;
        rst   = 1'b0;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid && first < 0)
                first = i;
        end
        checks++;
        if (first != 36)
            $display("FAIL post_reset_latency: got cycle %0d want 36", first);
        else
            passed++;
        checks++;
        if (last_code !== 4'd7)
            $display("FAIL post_reset_code: got %0d want 7", last_code);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_release_repress();
        test_bounce();
        test_two_keys();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
